// File: rtl/mdu_pkg.sv
// Shared encodings and defaults for the multiply/divide sequencer.
// The MDU_DIV_EN macro decides whether DIV/DIVU count as start ops.
package mdu_pkg;

  typedef enum logic [3:0] {
    MD_NONE  = 4'd0,
    MD_MULT  = 4'd1,
    MD_MULTU = 4'd2,
    MD_DIV   = 4'd3,
    MD_DIVU  = 4'd4,
    MD_MFHI  = 4'd5,
    MD_MFLO  = 4'd6,
    MD_MTHI  = 4'd7,
    MD_MTLO  = 4'd8
  } md_op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } md_state_e;

  localparam int unsigned MULT_CYCLES_DEF = 5;
  localparam int unsigned DIV_CYCLES_DEF  = 10;

  function automatic logic is_div_op(input md_op_e op);
`ifdef MDU_DIV_EN
    return (op == MD_DIV) || (op == MD_DIVU);
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic is_start_op(input md_op_e op);
    return (op == MD_MULT) || (op == MD_MULTU) || is_div_op(op);
  endfunction

endpackage

// File: rtl/mdu_arith.sv
// Combinational product / quotient-remainder generator for mdu_ctrl.
// Divider datapath exists only when MDU_DIV_EN is defined.
module mdu_arith
  import mdu_pkg::*;
(
  input  md_op_e      op_i,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o,
  output logic        wr_o
);

  logic signed [63:0] prod_s;
  logic        [63:0] prod_u;

  assign prod_s = $signed({{32{a_i[31]}}, a_i}) * $signed({{32{b_i[31]}}, b_i});
  assign prod_u = {32'd0, a_i} * {32'd0, b_i};

`ifdef MDU_DIV_EN
  logic               b_zero;
  logic               div_ovf;
  logic        [31:0] b_safe_s;
  logic        [31:0] b_safe_u;
  logic signed [31:0] q_s;
  logic signed [31:0] r_s;
  logic        [31:0] q_u;
  logic        [31:0] r_u;

  // Divide by 1 instead of 0 or INT_MIN/-1; INT_MIN/1 yields the wrapped result
  assign b_zero   = (b_i == 32'd0);
  assign div_ovf  = (a_i == 32'h8000_0000) && (b_i == 32'hFFFF_FFFF);
  assign b_safe_s = (b_zero || div_ovf) ? 32'd1 : b_i;
  assign b_safe_u = b_zero ? 32'd1 : b_i;
  assign q_s      = $signed(a_i) / $signed(b_safe_s);
  assign r_s      = $signed(a_i) % $signed(b_safe_s);
  assign q_u      = a_i / b_safe_u;
  assign r_u      = a_i % b_safe_u;
`endif

  always_comb begin
    hi_o = 32'd0;
    lo_o = 32'd0;
    wr_o = 1'b0;
    case (op_i)
      MD_MULT: begin
        hi_o = prod_s[63:32];
        lo_o = prod_s[31:0];
        wr_o = 1'b1;
      end
      MD_MULTU: begin
        hi_o = prod_u[63:32];
        lo_o = prod_u[31:0];
        wr_o = 1'b1;
      end
`ifdef MDU_DIV_EN
      MD_DIV: begin
        hi_o = r_s;
        lo_o = q_s;
        wr_o = !b_zero;
      end
      MD_DIVU: begin
        hi_o = r_u;
        lo_o = q_u;
        wr_o = !b_zero;
      end
`endif
      default: ;
    endcase
  end

endmodule

// File: rtl/mdu_ctrl.sv
// Multiply/divide sequencer: owns HI/LO, models fixed latency, requests D stalls.
// Define MDU_DIV_EN to build DIV/DIVU support; otherwise they behave as NONE.
module mdu_ctrl
  import mdu_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int unsigned DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  E_MDOp,
  input  logic [31:0] E_A,
  input  logic [31:0] E_B,
  input  logic        D_IsMD,
  output logic [31:0] E_MDOut,
  output logic        MD_Busy,
  output logic        D_MDStall,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  md_op_e      op;
  md_state_e   state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic [31:0] pend_hi_q, pend_hi_d;
  logic [31:0] pend_lo_q, pend_lo_d;
  logic        pend_wr_q, pend_wr_d;
  logic        start;
  logic [31:0] arith_hi;
  logic [31:0] arith_lo;
  logic        arith_wr;

  assign op    = md_op_e'(E_MDOp);
  assign start = (state_q == ST_IDLE) && is_start_op(op);

  mdu_arith u_arith (
    .op_i (op),
    .a_i  (E_A),
    .b_i  (E_B),
    .hi_o (arith_hi),
    .lo_o (arith_lo),
    .wr_o (arith_wr)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= 4'd0;
      hi_q      <= 32'd0;
      lo_q      <= 32'd0;
      pend_hi_q <= 32'd0;
      pend_lo_q <= 32'd0;
      pend_wr_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      pend_hi_q <= pend_hi_d;
      pend_lo_q <= pend_lo_d;
      pend_wr_q <= pend_wr_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    pend_hi_d = pend_hi_q;
    pend_lo_d = pend_lo_q;
    pend_wr_d = pend_wr_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          pend_hi_d = arith_hi;
          pend_lo_d = arith_lo;
          pend_wr_d = arith_wr;
          cnt_d     = is_div_op(op) ? DIV_CYCLES[3:0] : MULT_CYCLES[3:0];
          state_d   = ST_BUSY;
        end else if (op == MD_MTHI) begin
          hi_d = E_A;
        end else if (op == MD_MTLO) begin
          lo_d = E_A;
        end
      end
      ST_BUSY: begin
        // Results become architectural on the final count; divide-by-zero leaves HI/LO alone
        if (cnt_q == 4'd1) begin
          if (pend_wr_q) begin
            hi_d = pend_hi_q;
            lo_d = pend_lo_q;
          end
          cnt_d   = 4'd0;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    E_MDOut = 32'd0;
    if (op == MD_MFHI) begin
      E_MDOut = hi_q;
    end else if (op == MD_MFLO) begin
      E_MDOut = lo_q;
    end
  end

  assign MD_Busy   = (state_q == ST_BUSY);
  assign D_MDStall = D_IsMD && (start || MD_Busy);
  assign HI        = hi_q;
  assign LO        = lo_q;

endmodule

// File: tb/tb_mdu_ctrl.sv
// Directed testbench for mdu_ctrl; DIV checks follow the MDU_DIV_EN build option.
module tb_mdu_ctrl;
  import mdu_pkg::*;

  logic        clk;
  logic        reset;
  logic [3:0]  E_MDOp;
  logic [31:0] E_A;
  logic [31:0] E_B;
  logic        D_IsMD;
  logic [31:0] E_MDOut;
  logic        MD_Busy;
  logic        D_MDStall;
  logic [31:0] HI;
  logic [31:0] LO;

  int vectors;
  int miscompares;
  int n;

  mdu_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk       (clk),
    .reset     (reset),
    .E_MDOp    (E_MDOp),
    .E_A       (E_A),
    .E_B       (E_B),
    .D_IsMD    (D_IsMD),
    .E_MDOut   (E_MDOut),
    .MD_Busy   (MD_Busy),
    .D_MDStall (D_MDStall),
    .HI        (HI),
    .LO        (LO)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wait_idle(output int cycles);
    cycles = 0;
    while (MD_Busy === 1'b1 && cycles < 40) begin
      step();
      cycles++;
    end
  endtask

  // MTHI/MTLO must never reach E while the unit is busy
  always @(negedge clk) begin
    if (reset === 1'b1 && MD_Busy === 1'b1 &&
        (E_MDOp == MD_MTHI || E_MDOp == MD_MTLO)) begin
      miscompares++;
      $error("FAIL mt_in_busy: observed op %0d while busy, required none", E_MDOp);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout, required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vectors     = 0;
    miscompares = 0;
    reset  = 1'b0;
    E_MDOp = MD_NONE;
    E_A    = 32'd0;
    E_B    = 32'd0;
    D_IsMD = 1'b0;
    step();
    step();
    chk("rst_busy", 32'(MD_Busy), 32'd0);
    chk("rst_hi", HI, 32'd0);
    chk("rst_lo", LO, 32'd0);
    reset = 1'b1;
    step();

    // MULT signed with D-stage stall observation
    D_IsMD = 1'b1;
    E_MDOp = MD_MULT;
    E_A    = 32'hFFFF_FFFF;
    E_B    = 32'd2;
    #1;
    chk("stall_start", 32'(D_MDStall), 32'd1);
    chk("busy_pre", 32'(MD_Busy), 32'd0);
    step();
    E_MDOp = MD_NONE;
    for (int i = 0; i < 4; i++) begin
      chk("mult_busy", 32'(MD_Busy), 32'd1);
      chk("mult_stall", 32'(D_MDStall), 32'd1);
      step();
    end
    chk("mult_busy_last", 32'(MD_Busy), 32'd1);
    chk("mult_hi_hold", HI, 32'd0);
    step();
    chk("mult_done_busy", 32'(MD_Busy), 32'd0);
    chk("mult_done_stall", 32'(D_MDStall), 32'd0);
    chk("mult_hi", HI, 32'hFFFF_FFFF);
    chk("mult_lo", LO, 32'hFFFF_FFFE);
    E_MDOp = MD_MFHI;
    #1;
    chk("mfhi_mult", E_MDOut, 32'hFFFF_FFFF);
    E_MDOp = MD_MFLO;
    #1;
    chk("mflo_mult", E_MDOut, 32'hFFFF_FFFE);

    // MULTU back-to-back in the first idle cycle; a MULT arriving while busy is ignored
    D_IsMD = 1'b0;
    E_MDOp = MD_MULTU;
    E_A    = 32'hFFFF_FFFF;
    E_B    = 32'd2;
    step();
    chk("multu_b2b_busy", 32'(MD_Busy), 32'd1);
    E_MDOp = MD_MULT;
    E_A    = 32'd3;
    E_B    = 32'd3;
    step();
    E_MDOp = MD_NONE;
    wait_idle(n);
    chk("multu_cycles", 32'(n), 32'd4);
    chk("multu_hi", HI, 32'h0000_0001);
    chk("multu_lo", LO, 32'hFFFF_FFFE);
    step();
    chk("multu_no_restart", 32'(MD_Busy), 32'd0);

    // MTLO / MTHI single-cycle writes
    E_MDOp = MD_MTLO;
    E_A    = 32'h0000_1234;
    step();
    chk("mtlo_lo", LO, 32'h0000_1234);
    chk("mtlo_busy", 32'(MD_Busy), 32'd0);
    chk("mtlo_hi_keep", HI, 32'h0000_0001);
    E_MDOp = MD_MFLO;
    #1;
    chk("mflo_mtlo", E_MDOut, 32'h0000_1234);
    E_MDOp = MD_MTHI;
    E_A    = 32'hCAFE_0000;
    step();
    chk("mthi_busy", 32'(MD_Busy), 32'd0);
    E_MDOp = MD_MFHI;
    #1;
    chk("mfhi_mthi", E_MDOut, 32'hCAFE_0000);
    E_MDOp = MD_NONE;
    #1;
    chk("mdout_none", E_MDOut, 32'd0);

`ifdef MDU_DIV_EN
    E_MDOp = MD_DIV;
    E_A    = 32'hFFFF_FFF9;
    E_B    = 32'd2;
    step();
    E_MDOp = MD_NONE;
    wait_idle(n);
    chk("div_cycles", 32'(n), 32'd10);
    chk("div_lo", LO, 32'hFFFF_FFFD);
    chk("div_hi", HI, 32'hFFFF_FFFF);
    E_MDOp = MD_DIVU;
    E_A    = 32'd7;
    E_B    = 32'd0;
    step();
    E_MDOp = MD_NONE;
    wait_idle(n);
    chk("divz_cycles", 32'(n), 32'd10);
    chk("divz_lo", LO, 32'hFFFF_FFFD);
    chk("divz_hi", HI, 32'hFFFF_FFFF);
    E_MDOp = MD_DIVU;
    E_A    = 32'd100;
    E_B    = 32'd7;
    step();
    E_MDOp = MD_NONE;
    wait_idle(n);
    chk("divu_lo", LO, 32'h0000_000E);
    chk("divu_hi", HI, 32'h0000_0002);
`else
    D_IsMD = 1'b1;
    E_MDOp = MD_DIV;
    E_A    = 32'hFFFF_FFF9;
    E_B    = 32'd2;
    #1;
    chk("nodiv_stall", 32'(D_MDStall), 32'd0);
    step();
    chk("nodiv_busy", 32'(MD_Busy), 32'd0);
    E_MDOp = MD_DIVU;
    step();
    E_MDOp = MD_NONE;
    chk("nodivu_busy", 32'(MD_Busy), 32'd0);
    chk("nodiv_hi", HI, 32'hCAFE_0000);
    chk("nodiv_lo", LO, 32'h0000_1234);
    D_IsMD = 1'b0;
`endif

    // Asynchronous reset in the middle of a multiply
    E_MDOp = MD_MULT;
    E_A    = 32'd5;
    E_B    = 32'd7;
    step();
    E_MDOp = MD_NONE;
    step();
    reset = 1'b0;
    #1;
    chk("rstmid_busy", 32'(MD_Busy), 32'd0);
    chk("rstmid_hi", HI, 32'd0);
    chk("rstmid_lo", LO, 32'd0);
    step();
    reset = 1'b1;
    step();
    chk("rstmid_idle", 32'(MD_Busy), 32'd0);
    E_MDOp = MD_MULT;
    step();
    E_MDOp = MD_NONE;
    wait_idle(n);
    chk("post_rst_cycles", 32'(n), 32'd5);
    chk("post_rst_hi", HI, 32'd0);
    chk("post_rst_lo", LO, 32'h0000_0023);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
